// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: FSM encoding, bus
// transfer size and the two architectural fetch entry points.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } fetch_state_t;

  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [31:0] BOOT_PC   = 32'hbfc0_0000;
  localparam logic [31:0] EXC_PC    = 32'hbfc0_0380;

endpackage

// File: rtl/inst_fetch_bridge.sv
// Fetch bridge between the IF PC generator and an SRAM-like instruction bus.
// Issues one word read per PC, keeps at most one request outstanding, holds IF
// until the word is handed to ID, and discards responses that a flush has
// made stale. Misaligned PCs never reach the bus; they come back as adel_o.
module inst_fetch_bridge
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             flush_i,
  input  logic             stall_d_i,
  output logic             stall_f_o,
  output logic             inst_valid_o,
  output logic [WIDTH-1:0] inst_o,
  output logic [WIDTH-1:0] inst_pc_o,
  output logic             adel_o,
  output logic             inst_req_o,
  output logic             inst_wr_o,
  output logic [1:0]       inst_size_o,
  output logic [WIDTH-1:0] inst_addr_o,
  input  logic             inst_addr_ok_i,
  input  logic             inst_data_ok_i,
  input  logic [WIDTH-1:0] inst_rdata_i
);

  fetch_state_t     state_reg, state_next;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] inst_reg;
  logic             adel_reg;
  logic             flush_pend_reg;
  logic             misaligned;

  assign misaligned = (pc_i[1:0] != 2'b00);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A request, once raised, is held until the bus accepts
  // it; a flush seen while requesting is remembered so the answer gets drained.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (!flush_i) begin
          state_next = misaligned ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (inst_addr_ok_i) begin
          state_next = (flush_pend_reg || flush_i) ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok_i) begin
          state_next = flush_i ? S_IDLE : S_DONE;
        end else if (flush_i) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inst_data_ok_i) begin
          state_next = S_IDLE;
        end
      end
      S_DONE: begin
        if (flush_i || !stall_d_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Address, instruction word, error flag and pending-flush bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg       <= '0;
      inst_reg       <= '0;
      adel_reg       <= 1'b0;
      flush_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (!flush_i) begin
            addr_reg <= pc_i;
            adel_reg <= misaligned;
            inst_reg <= '0;
          end
        end
        S_REQ: begin
          if (flush_i) begin
            flush_pend_reg <= 1'b1;
          end
        end
        S_WAIT: begin
          if (inst_data_ok_i && !flush_i) begin
            inst_reg <= inst_rdata_i;
          end
        end
        S_DRAIN: begin
          if (inst_data_ok_i) begin
            flush_pend_reg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bus and ID outputs are pure state decodes; only stall_f_o looks at inputs
  // so that IF advances its PC exactly on the delivery cycle.
  assign inst_req_o   = (state_reg == S_REQ);
  assign inst_valid_o = (state_reg == S_DONE);
  assign stall_f_o    = !((state_reg == S_DONE) && !stall_d_i && !flush_i);
  assign inst_wr_o    = 1'b0;
  assign inst_size_o  = SIZE_WORD;
  assign inst_addr_o  = addr_reg;
  assign inst_pc_o    = addr_reg;
  assign inst_o       = inst_reg;
  assign adel_o       = adel_reg;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: the bench plays the IF stage (PC register that
// advances on delivery, jumps on flush) and the instruction memory (random
// accept/return latency). Whatever ID receives must be the memory word of the
// PC that IF currently holds.
module tb_inst_fetch_bridge;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = BOOT_PC;
  logic        flush_i = 1'b0;
  logic        stall_d_i = 1'b0;
  logic        stall_f_o, inst_valid_o, adel_o, inst_req_o, inst_wr_o;
  logic [31:0] inst_o, inst_pc_o, inst_addr_o;
  logic [1:0]  inst_size_o;
  logic        inst_addr_ok_i = 1'b0;
  logic        inst_data_ok_i = 1'b0;
  logic [31:0] inst_rdata_i = '0;

  always #5 clk = ~clk;

  inst_fetch_bridge #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .flush_i(flush_i), .stall_d_i(stall_d_i),
    .stall_f_o(stall_f_o), .inst_valid_o(inst_valid_o), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .adel_o(adel_o), .inst_req_o(inst_req_o),
    .inst_wr_o(inst_wr_o), .inst_size_o(inst_size_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Environment state
  logic [31:0] if_pc = BOOT_PC;
  bit          rand_mode = 0;
  bit          stall_ctl = 0, flush_ctl = 0;
  logic [31:0] flush_pc_ctl = BOOT_PC;
  int          fix_a = 0, fix_d = 0;
  int          a_lat = 0, a_cnt = 0, d_lat = 0, d_cnt = 0;
  bit          pending = 0;
  logic [31:0] pend_addr = '0;
  bit          force_rdata = 0, stale_returned = 0;
  bit          prev_req = 0, prev_aok = 0;
  logic [31:0] prev_addr = '0;
  bit          seen_req = 0, seen_valid = 0;
  int          quiet = 0, dlv_count = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == BOOT_PC) return 32'h2408_0001;
    return (a * 32'h9e37_79b1) ^ 32'h5a5a_1234;
  endfunction

  function automatic int new_alat();
    return (fix_a >= 0) ? fix_a : int'($urandom_range(0, 5));
  endfunction

  function automatic int new_dlat();
    return (fix_d >= 0) ? fix_d : int'($urandom_range(0, 4));
  endfunction

  function automatic logic [31:0] pick_pc(input logic [31:0] cur);
    logic [31:0] p;
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0)      p = BOOT_PC + {22'd0, 8'($urandom_range(0, 63)), 2'b00} + 32'($urandom_range(1, 3));
    else if (r == 1) p = EXC_PC;
    else if (r == 2) p = BOOT_PC;
    else             p = BOOT_PC + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if (p == cur) p = p + 32'd8;
    return p;
  endfunction

  task automatic set_lat(input int a, input int d);
    fix_a = a;
    fix_d = d;
    a_lat = new_alat();
  endtask

  // One clock cycle: drive at the falling edge, observe 1ns later, then
  // advance the IF and memory models to what the next rising edge commits.
  task automatic cycle();
    bit st, fl;
    logic [31:0] fpc;
    @(negedge clk);
    pc_i = if_pc;
    if (rand_mode) begin
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 11) == 0);
      fpc = pick_pc(if_pc);
    end else begin
      st  = stall_ctl;
      fl  = flush_ctl;
      fpc = flush_pc_ctl;
    end
    stall_d_i      = st;
    flush_i        = fl;
    inst_addr_ok_i = inst_req_o && (a_cnt >= a_lat);
    inst_data_ok_i = pending && (d_cnt >= d_lat);
    if (inst_data_ok_i) inst_rdata_i = force_rdata ? 32'hdead_beef : mem_word(pend_addr);
    else                inst_rdata_i = $urandom();
    #1;
    if (inst_req_o)   seen_req = 1;
    if (inst_valid_o) seen_valid = 1;
    // ID side: a delivery must carry the word of IF's current PC
    if (!stall_f_o) begin
      check("dlv_valid", 32'(inst_valid_o), 1);
      check("dlv_gate", {30'd0, st, fl}, 0);
      check("dlv_pc", inst_pc_o, if_pc);
      check("dlv_adel", 32'(adel_o), 32'(if_pc[1:0] != 2'b00));
      check("dlv_inst", inst_o, (if_pc[1:0] != 2'b00) ? 32'd0 : mem_word(if_pc));
    end
    if (inst_valid_o && !st && !fl) check("stallf_low", 32'(stall_f_o), 0);
    // Bus side
    if (prev_req && !prev_aok) begin
      check("req_held", 32'(inst_req_o), 1);
      check("req_addr_stable", inst_addr_o, prev_addr);
    end else if (inst_req_o) begin
      check("req_addr", inst_addr_o, if_pc);
    end
    if (inst_req_o) begin
      check("req_align", 32'(inst_addr_o[1:0]), 0);
      check("req_one_outstanding", 32'(pending), 0);
      check("req_wr", 32'(inst_wr_o), 0);
      check("req_size", 32'(inst_size_o), 32'(SIZE_WORD));
    end
    // IF model
    if (!stall_f_o) begin
      dlv_count++;
      quiet = 0;
      $display("dlv pc=%h inst=%h adel=%0d", inst_pc_o, inst_o, adel_o);
    end else begin
      quiet++;
    end
    if (fl) begin
      if_pc = fpc;
      quiet = 0;
    end else if (!stall_f_o) begin
      if_pc = if_pc + 32'd4;
    end
    if (quiet > 40) begin
      check("progress", 32'(quiet), 0);
      quiet = 0;
    end
    // Memory model
    if (inst_data_ok_i) begin
      pending = 0;
      if (force_rdata) begin
        force_rdata = 0;
        stale_returned = 1;
      end
    end else if (pending) begin
      d_cnt++;
    end
    if (inst_req_o && inst_addr_ok_i) begin
      pending   = 1;
      pend_addr = inst_addr_o;
      d_cnt     = 0;
      d_lat     = new_dlat();
      a_cnt     = 0;
      a_lat     = new_alat();
    end else if (inst_req_o) begin
      a_cnt++;
    end
    prev_req  = inst_req_o;
    prev_aok  = inst_addr_ok_i;
    prev_addr = inst_addr_o;
  endtask

  // what: 0 = bus request visible, 1 = inst_valid_o, 2 = delivery
  task automatic run_until(input int what, input int bound, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < bound; i++) begin
      cycle();
      if ((what == 0 && inst_req_o) || (what == 1 && inst_valid_o) || (what == 2 && !stall_f_o)) begin
        hit = 1;
        break;
      end
    end
    check(tag, 32'(hit), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    inst_addr_ok_i = 0;
    inst_data_ok_i = 0;
    flush_i = 0;
    stall_d_i = 0;
    pending = 0;
    a_cnt = 0;
    d_cnt = 0;
    prev_req = 0;
    prev_aok = 0;
    force_rdata = 0;
    quiet = 0;
    if_pc = BOOT_PC;
    pc_i = if_pc;
    #1;
    check("rst_req", 32'(inst_req_o), 0);
    check("rst_valid", 32'(inst_valid_o), 0);
    check("rst_stallf", 32'(stall_f_o), 1);
    check("rst_inst", inst_o, 0);
    check("rst_pc", inst_pc_o, 0);
    check("rst_addr", inst_addr_o, 0);
    check("rst_adel", 32'(adel_o), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 0;
  endtask

  logic [4:0]  vbits, sbits;
  logic [31:0] cap_inst, cap_pc, t4_pc;
  int          nreq;

  initial begin
    // 1: back-to-back minimum latency fetch from the boot vector
    set_lat(0, 0);
    do_reset();
    set_lat(0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      vbits[i] = inst_valid_o;
      sbits[i] = stall_f_o;
      if (i == 3) begin
        cap_inst = inst_o;
        cap_pc   = inst_pc_o;
      end
    end
    check("t1_valid_seq", 32'(vbits), 32'b01000);
    check("t1_stallf_seq", 32'(sbits), 32'b10111);
    check("t1_inst", cap_inst, 32'h2408_0001);
    check("t1_pc", cap_pc, BOOT_PC);

    // 2: ID stalls for three cycles while the word is ready
    stall_ctl = 1;
    run_until(1, 20, "t2_reach_done");
    cap_inst = inst_o;
    check("t2_stallf_0", 32'(stall_f_o), 1);
    for (int k = 0; k < 2; k++) begin
      cycle();
      check("t2_valid_hold", 32'(inst_valid_o), 1);
      check("t2_inst_hold", inst_o, cap_inst);
      check("t2_pc_hold", inst_pc_o, BOOT_PC + 32'd4);
      check("t2_stallf_hold", 32'(stall_f_o), 1);
    end
    stall_ctl = 0;
    cycle();
    check("t2_deliver", 32'(stall_f_o), 0);
    check("t2_deliver_pc", inst_pc_o, BOOT_PC + 32'd4);

    // 3: flush while waiting for data; the stale word must be swallowed
    set_lat(0, 2);
    run_until(0, 10, "t3_req");
    flush_ctl = 1;
    flush_pc_ctl = EXC_PC;
    force_rdata = 1;
    stale_returned = 0;
    cycle();
    flush_ctl = 0;
    seen_valid = 0;
    run_until(0, 15, "t3_next_req");
    check("t3_next_addr", inst_addr_o, EXC_PC);
    check("t3_stale_returned", 32'(stale_returned), 1);
    check("t3_no_stale_valid", 32'(seen_valid), 0);
    run_until(2, 15, "t3_dlv");
    check("t3_dlv_pc", inst_pc_o, EXC_PC);
    check("t3_dlv_inst", inst_o, mem_word(EXC_PC));

    // 4: flush while the request waits for acceptance
    set_lat(3, 0);
    run_until(0, 10, "t4_req");
    nreq = 1;
    t4_pc = BOOT_PC + 32'h40;
    flush_ctl = 1;
    flush_pc_ctl = t4_pc;
    cycle();
    flush_ctl = 0;
    if (inst_req_o) nreq++;
    for (int i = 0; i < 10 && inst_req_o; i++) begin
      cycle();
      if (inst_req_o) nreq++;
    end
    check("t4_req_cycles", 32'(nreq), 4);
    seen_valid = 0;
    run_until(0, 15, "t4_fresh_req");
    check("t4_fresh_addr", inst_addr_o, t4_pc);
    check("t4_no_stale_valid", 32'(seen_valid), 0);
    run_until(2, 20, "t4_dlv");
    check("t4_dlv_pc", inst_pc_o, t4_pc);

    // 5: misaligned PC produces an address error without touching the bus
    set_lat(-1, -1);
    flush_ctl = 1;
    flush_pc_ctl = BOOT_PC + 32'd2;
    cycle();
    flush_ctl = 0;
    seen_req = 0;
    run_until(1, 10, "t5_valid");
    check("t5_adel", 32'(adel_o), 1);
    check("t5_inst", inst_o, 0);
    check("t5_pc", inst_pc_o, BOOT_PC + 32'd2);
    check("t5_no_req", 32'(seen_req), 0);
    flush_ctl = 1;
    flush_pc_ctl = BOOT_PC;
    cycle();
    flush_ctl = 0;

    // 6: reset between clock edges takes effect immediately
    set_lat(5, 0);
    run_until(0, 10, "t6_req");
    #2 rst = 1;
    #1;
    check("t6_async_req", 32'(inst_req_o), 0);
    check("t6_async_stallf", 32'(stall_f_o), 1);
    check("t6_async_addr", inst_addr_o, 0);
    do_reset();
    set_lat(-1, -1);
    stall_ctl = 1;
    run_until(1, 20, "t6_done");
    #2 rst = 1;
    #1;
    check("t6_async_valid", 32'(inst_valid_o), 0);
    check("t6_async_inst", inst_o, 0);
    do_reset();
    stall_ctl = 0;

    // Random soak against the IF/memory model
    set_lat(-1, -1);
    rand_mode = 1;
    dlv_count = 0;
    repeat (3000) cycle();
    rand_mode = 0;
    check("soak_deliveries", 32'(dlv_count >= 100), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
